// File: rtl/id_track_table.sv
// id_track_table: outstanding AXI ID tracker with per-ID counters, retire on last beat, unexpected-response flag
module id_track_table #(
   parameter int unsigned IdWidth    = 4,
   parameter int unsigned NumEntries = 8,
   parameter int unsigned CntWidth   = 4,
   parameter int unsigned IdxWidth   = $clog2(NumEntries)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                alloc_valid_i,
   output logic                alloc_ready_o,
   input  logic [IdWidth-1:0]  alloc_id_i,
   output logic [IdxWidth-1:0] alloc_idx_o,
   input  logic                rsp_valid_i,
   input  logic                rsp_last_i,
   input  logic [IdWidth-1:0]  rsp_id_i,
   output logic                rsp_hit_o,
   output logic [IdxWidth-1:0] rsp_idx_o,
   output logic                rsp_err_o,
   output logic                full_o,
   output logic                empty_o,
   output logic [IdxWidth:0]   num_used_o
);
   localparam logic [CntWidth-1:0] CntMax = '1;

   logic [NumEntries-1:0] used_q, used_d;
   logic [IdWidth-1:0]    id_q  [NumEntries];
   logic [IdWidth-1:0]    id_d  [NumEntries];
   logic [CntWidth-1:0]   cnt_q [NumEntries];
   logic [CntWidth-1:0]   cnt_d [NumEntries];
   logic                  rsp_err_q, rsp_err_d;
   logic                  alloc_hit, alloc_fire, retire, inc, dec;
   logic [IdxWidth-1:0]   hit_idx, free_idx;

   // Descending scan so the lowest matching/free index wins
   always_comb begin
      alloc_hit  = 1'b0;
      hit_idx    = '0;
      free_idx   = '0;
      rsp_hit_o  = 1'b0;
      rsp_idx_o  = '0;
      num_used_o = '0;
      for (int i = int'(NumEntries) - 1; i >= 0; i--) begin
         if (used_q[i] && id_q[i] == alloc_id_i) begin
            alloc_hit = 1'b1;
            hit_idx   = IdxWidth'(i);
         end
         if (!used_q[i]) free_idx = IdxWidth'(i);
         if (used_q[i] && id_q[i] == rsp_id_i) begin
            rsp_hit_o = 1'b1;
            rsp_idx_o = IdxWidth'(i);
         end
         num_used_o = num_used_o + (IdxWidth+1)'(used_q[i]);
      end
   end

   assign full_o        = &used_q;
   assign empty_o       = ~|used_q;
   assign alloc_idx_o   = alloc_hit ? hit_idx : free_idx;
   assign alloc_ready_o = alloc_hit ? (cnt_q[hit_idx] != CntMax) : !full_o;
   assign alloc_fire    = alloc_valid_i && alloc_ready_o;
   assign retire        = rsp_valid_i && rsp_last_i && rsp_hit_o;
   assign rsp_err_d     = rsp_valid_i && !rsp_hit_o;
   assign rsp_err_o     = rsp_err_q;

   // An alloc and a retire on the same entry cancel out
   always_comb begin
      used_d = used_q;
      id_d   = id_q;
      cnt_d  = cnt_q;
      inc    = 1'b0;
      dec    = 1'b0;
      for (int i = 0; i < int'(NumEntries); i++) begin
         inc = alloc_fire && alloc_idx_o == IdxWidth'(i);
         dec = retire && rsp_idx_o == IdxWidth'(i);
         if (inc && !dec) begin
            used_d[i] = 1'b1;
            id_d[i]   = used_q[i] ? id_q[i] : alloc_id_i;
            cnt_d[i]  = used_q[i] ? cnt_q[i] + CntWidth'(1) : CntWidth'(1);
         end else if (dec && !inc) begin
            cnt_d[i]  = cnt_q[i] - CntWidth'(1);
            used_d[i] = cnt_q[i] != CntWidth'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         used_q    <= '0;
         rsp_err_q <= 1'b0;
         for (int i = 0; i < int'(NumEntries); i++) begin
            id_q[i]  <= '0;
            cnt_q[i] <= '0;
         end
      end else begin
         used_q    <= used_d;
         rsp_err_q <= rsp_err_d;
         id_q      <= id_d;
         cnt_q     <= cnt_d;
      end
   end
endmodule
